// File: rtl/word_swap_responder_if.sv
// Word-stream bundle between a bench-side producer/checker and word_swap_responder.
// Pure wiring: no latency of its own.
// No backpressure signal; the producer watches full/count and the responder drops on overflow.
interface word_swap_responder_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          enable;
   logic [31:0]   din;
   logic [31:0]   dout;
   logic          valid;
   logic          full;
   logic [CW-1:0] count;
   logic          overflow;
   logic [15:0]   drop_cnt;

   // Producer / checker side
   modport master (
      output enable, din,
      input  dout, valid, full, count, overflow, drop_cnt
   );

   // Responder side
   modport slave (
      input  enable, din,
      output dout, valid, full, count, overflow, drop_cnt
   );
endinterface

// File: rtl/word_swap_responder.sv
// Buffers incoming 32-bit words in a DEPTH-entry FIFO and re-emits them half-swapped, at most one per GAP edges.
// Latency: one cycle from capture into an empty FIFO to the valid pulse (no same-cycle bypass).
// Backpressure: none upstream; a word offered while full is dropped unless a pop frees a slot on that edge.
module word_swap_responder #(
   parameter int DEPTH = 8,
   parameter int GAP   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   word_swap_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] lo;
   } word_t;

   // IDLE/READY/HOLD are not stored; they are decoded from the gap counter and occupancy.
   typedef enum logic [1:0] {
      IDLE,
      READY,
      HOLD
   } phase_t;

   // Storage and pointers
   word_t         mem [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   word_t         head;

   // Emitter state
   phase_t        phase;
   logic [GW-1:0] gap_q, gap_d;
   word_t         dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   drop_q, drop_d;

   // Handshake decisions
   logic          pop, wr, drop;

   assign head = mem[rptr_q];

   // Decode the implicit phase: a running gap always holds, otherwise occupancy decides.
   always_comb begin
      phase = IDLE;
      if (gap_q != '0) begin
         phase = HOLD;
      end else if (count_q != '0) begin
         phase = READY;
      end
   end

   // Pop/write/drop decisions and next values for occupancy, emitter and sticky status.
   always_comb begin
      pop        = (phase == READY);
      wr         = bus.enable && (!full_q || pop);
      drop       = bus.enable && full_q && !pop;

      count_d    = count_q;
      gap_d      = gap_q;
      dout_d     = dout_q;
      valid_d    = 1'b0;
      overflow_d = overflow_q;
      drop_d     = drop_q;

      if (wr && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !wr) begin
         count_d = count_q - CNT_ONE;
      end
      full_d = (count_d == CNT_FULL);

      if (pop) begin
         dout_d.hi = head.lo;
         dout_d.lo = head.hi;
         valid_d   = 1'b1;
         gap_d     = GAP_LOAD;
      end else if (gap_q != '0) begin
         gap_d = gap_q - GAP_ONE;
      end

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
         end
      end
   end

   // State registers; reset wins over any same-edge write or pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         gap_q      <= '0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         if (wr) begin
            wptr_q <= wptr_q + PTR_ONE;
         end
         if (pop) begin
            rptr_q <= rptr_q + PTR_ONE;
         end
         count_q    <= count_d;
         full_q     <= full_d;
         gap_q      <= gap_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // Word storage; contents need no reset because the pointers define what is live.
   always_ff @(posedge clk) begin
      if (wr && !rst) begin
         mem[wptr_q] <= bus.din;
      end
   end

   assign bus.dout     = dout_q;
   assign bus.valid    = valid_q;
   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_word_swap_responder.sv
// Bench for word_swap_responder: one instance with GAP=1 and one with GAP=4 see identical input.
// Each is checked every cycle against a queue-style reference model kept here.
// Directed table, hand-written corner sequences, then randomized traffic.
module tb_word_swap_responder;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int SMAX  = 4096;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   word_swap_responder_if #(.DEPTH(DEPTH)) b1 ();
   word_swap_responder_if #(.DEPTH(DEPTH)) b4 ();

   word_swap_responder #(.DEPTH(DEPTH), .GAP(1)) u_g1 (.clk(clk), .rst(rst), .bus(b1.slave));
   word_swap_responder #(.DEPTH(DEPTH), .GAP(4)) u_g4 (.clk(clk), .rst(rst), .bus(b4.slave));

   int checks = 0;
   int errors = 0;

   // Reference model: every accepted word is kept by acceptance number.
   logic [31:0] store [2][SMAX];
   int          acc [2];
   int          emi [2];
   int          last [2];
   logic [31:0] m_dout [2];
   bit          m_valid [2];
   bit          m_ovf [2];
   logic [15:0] m_drops [2];
   int          cyc = 0;

   int          pulses [2];
   int          maxcnt [2];
   bit          sawfull [2];
   int          ptimes4 [$];
   logic [31:0] outq1 [$];

   typedef struct {
      bit          rst;
      bit          en;
      logic [31:0] din;
      bit          exp_valid;
      logic [31:0] exp_dout;
      int          exp_count;
      bit          exp_ovf;
   } vec_t;
   vec_t vecs [6];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int gapof(int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic bit will_pop(int k);
      return ((acc[k] - emi[k]) > 0) && ((cyc - last[k]) >= gapof(k));
   endfunction

   task automatic model_step(int k, bit r, bit e, logic [31:0] d);
      bit          p, w, dr;
      int          occ;
      logic [31:0] h;
      if (r) begin
         acc[k] = 0; emi[k] = 0; last[k] = -100;
         m_dout[k] = '0; m_valid[k] = 0; m_ovf[k] = 0; m_drops[k] = '0;
         return;
      end
      occ = acc[k] - emi[k];
      p   = will_pop(k);
      w   = e && (occ < DEPTH || p);
      dr  = e && (occ == DEPTH) && !p;
      m_valid[k] = p;
      if (p) begin
         h = store[k][emi[k] % SMAX];
         m_dout[k] = {h[15:0], h[31:16]};
         emi[k]++;
         last[k] = cyc;
      end
      if (w) begin
         store[k][acc[k] % SMAX] = d;
         acc[k]++;
      end
      if (dr) begin
         m_ovf[k] = 1;
         if (m_drops[k] != 16'hFFFF) m_drops[k] = m_drops[k] + 16'd1;
      end
   endtask

   task automatic cmp_dut(int k, logic v, logic [31:0] dout, logic [CW-1:0] cnt,
                          logic f, logic o, logic [15:0] dc);
      int occ;
      occ = acc[k] - emi[k];
      check($sformatf("cyc%0d dut%0d valid", cyc, k), 32'(v), 32'(m_valid[k]));
      check($sformatf("cyc%0d dut%0d dout", cyc, k), dout, m_dout[k]);
      check($sformatf("cyc%0d dut%0d count", cyc, k), 32'(cnt), 32'(occ));
      check($sformatf("cyc%0d dut%0d full", cyc, k), 32'(f), 32'(occ == DEPTH));
      check($sformatf("cyc%0d dut%0d overflow", cyc, k), 32'(o), 32'(m_ovf[k]));
      check($sformatf("cyc%0d dut%0d drop_cnt", cyc, k), 32'(dc), 32'(m_drops[k]));
   endtask

   // One clock: drive, advance the model, take the edge, sample 1 time unit later.
   task automatic cycle(bit r, bit e, logic [31:0] d);
      rst = r;
      b1.enable = e; b1.din = d;
      b4.enable = e; b4.din = d;
      model_step(0, r, e, d);
      model_step(1, r, e, d);
      @(posedge clk);
      #1;
      cmp_dut(0, b1.valid, b1.dout, b1.count, b1.full, b1.overflow, b1.drop_cnt);
      cmp_dut(1, b4.valid, b4.dout, b4.count, b4.full, b4.overflow, b4.drop_cnt);
      if (b1.valid) begin pulses[0]++; outq1.push_back(b1.dout); end
      if (b4.valid) begin pulses[1]++; ptimes4.push_back(cyc); end
      if (int'(b1.count) > maxcnt[0]) maxcnt[0] = int'(b1.count);
      if (int'(b4.count) > maxcnt[1]) maxcnt[1] = int'(b4.count);
      if (b1.full) sawfull[0] = 1;
      if (b4.full) sawfull[1] = 1;
      cyc++;
   endtask

   task automatic clear_stats();
      for (int k = 0; k < 2; k++) begin
         pulses[k] = 0; maxcnt[k] = 0; sawfull[k] = 0;
      end
      ptimes4.delete();
      outq1.delete();
   endtask

   initial begin
      int          dc_before;
      int          bursts [6];
      int          dens;
      logic [15:0] i16;
      logic [31:0] w;

      rst = 1'b1;
      b1.enable = 1'b0; b1.din = '0;
      b4.enable = 1'b0; b4.din = '0;

      // Reset with enable held, then one pass-through word
      vecs[0] = '{1, 1, 32'h55AA_55AA, 0, 32'h0, 0, 0};
      vecs[1] = '{1, 1, 32'h55AA_55AA, 0, 32'h0, 0, 0};
      vecs[2] = '{1, 1, 32'h55AA_55AA, 0, 32'h0, 0, 0};
      vecs[3] = '{0, 1, 32'h1234_ABCD, 0, 32'h0, 1, 0};
      vecs[4] = '{0, 0, 32'h0,         1, 32'hABCD_1234, 0, 0};
      vecs[5] = '{0, 0, 32'h0,         0, 32'hABCD_1234, 0, 0};
      for (int v = 0; v < 6; v++) begin
         cycle(vecs[v].rst, vecs[v].en, vecs[v].din);
         check($sformatf("vec%0d g1 valid", v), 32'(b1.valid), 32'(vecs[v].exp_valid));
         check($sformatf("vec%0d g1 dout", v), b1.dout, vecs[v].exp_dout);
         check($sformatf("vec%0d g1 count", v), 32'(b1.count), 32'(vecs[v].exp_count));
         check($sformatf("vec%0d g1 overflow", v), 32'(b1.overflow), 32'(vecs[v].exp_ovf));
         check($sformatf("vec%0d g4 valid", v), 32'(b4.valid), 32'(vecs[v].exp_valid));
         check($sformatf("vec%0d g4 dout", v), b4.dout, vecs[v].exp_dout);
         check($sformatf("vec%0d g4 count", v), 32'(b4.count), 32'(vecs[v].exp_count));
      end

      // Stream order: 20 words, enable every other cycle
      cycle(1, 0, 0);
      clear_stats();
      for (int i = 0; i < 20; i++) begin
         i16 = 16'(i);
         cycle(0, 1, {i16, ~i16});
         cycle(0, 0, 0);
      end
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);
      check("stream g1 pulses", 32'(pulses[0]), 32'd20);
      check("stream g1 max count", 32'(maxcnt[0]), 32'd1);
      check("stream g1 overflow", 32'(b1.overflow), 32'd0);
      for (int i = 0; i < 20; i++) begin
         i16 = 16'(i);
         w = (i < outq1.size()) ? outq1[i] : 32'hDEAD_BEEF;
         check($sformatf("stream g1 word%0d", i), w, {~i16, i16});
      end

      // Overflow with GAP=4: 12 back-to-back words, exactly one drop
      cycle(1, 0, 0);
      clear_stats();
      for (int i = 0; i < 12; i++) cycle(0, 1, $urandom);
      for (int i = 0; i < 50; i++) cycle(0, 0, 0);
      check("ovf g4 saw full", 32'(sawfull[1]), 32'd1);
      check("ovf g4 overflow", 32'(b4.overflow), 32'd1);
      check("ovf g4 drop_cnt", 32'(b4.drop_cnt), 32'd1);
      check("ovf g4 pulses", 32'(pulses[1]), 32'd11);
      check("ovf g1 drop_cnt", 32'(b1.drop_cnt), 32'd0);
      for (int i = 1; i < ptimes4.size(); i++)
         check($sformatf("ovf g4 spacing%0d", i), 32'(ptimes4[i] - ptimes4[i-1]), 32'd4);

      // Full FIFO with a write on the popping edge
      cycle(1, 0, 0);
      clear_stats();
      for (int n = 0; n < 40 && (acc[1] - emi[1]) < DEPTH; n++) cycle(0, 1, $urandom);
      check("fullpop g4 filled", 32'(b4.count), 32'(DEPTH));
      for (int n = 0; n < 10 && !will_pop(1); n++) cycle(0, 0, 0);
      dc_before = int'(b4.drop_cnt);
      cycle(0, 1, 32'hCAFE_F00D);
      check("fullpop g4 count", 32'(b4.count), 32'(DEPTH));
      check("fullpop g4 full", 32'(b4.full), 32'd1);
      check("fullpop g4 drop_cnt", 32'(b4.drop_cnt), 32'(dc_before));

      // Wrap-around: 3*DEPTH+3 words in partial fills and drains
      cycle(1, 0, 0);
      clear_stats();
      bursts = '{5, 7, 3, 6, 2, 4};
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < bursts[b]; i++) cycle(0, 1, $urandom);
         for (int i = 0; i < 3; i++) cycle(0, 0, 0);
      end
      for (int i = 0; i < 40; i++) cycle(0, 0, 0);
      check("wrap g1 pulses", 32'(pulses[0]), 32'(3 * DEPTH + 3));
      check("wrap g4 pulses", 32'(pulses[1]), 32'(acc[1]));
      check("wrap g4 drained", 32'(b4.count), 32'd0);

      // Reset mid-operation with count=5 and overflow set
      cycle(1, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, 1, $urandom);
      for (int n = 0; n < 40 && (acc[1] - emi[1]) != 5; n++) cycle(0, 0, 0);
      check("midrst g4 pre count", 32'(b4.count), 32'd5);
      check("midrst g4 pre overflow", 32'(b4.overflow), 32'd1);
      cycle(1, 0, 0);
      check("midrst g4 count", 32'(b4.count), 32'd0);
      check("midrst g4 overflow", 32'(b4.overflow), 32'd0);
      check("midrst g4 drop_cnt", 32'(b4.drop_cnt), 32'd0);
      clear_stats();
      for (int i = 0; i < 10; i++) cycle(0, 0, 0);
      check("midrst g4 silent", 32'(pulses[1]), 32'd0);
      cycle(0, 1, 32'h0BAD_F00D);
      cycle(0, 0, 0);
      check("midrst g4 new valid", 32'(b4.valid), 32'd1);
      check("midrst g4 new dout", b4.dout, 32'hF00D_0BAD);

      // Randomized traffic with varying density and rare resets
      dens = 50;
      for (int n = 0; n < 1500; n++) begin
         if (n % 100 == 0) dens = $urandom_range(10, 90);
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < dens, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
